// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between two decoded-instruction stages: valid/ready handshake,
// optional two-entry skid buffer, synchronous flush and bubble control on empty.
module pipe_stage_reg #(
  parameter int unsigned       CTRL_W      = 13,
  parameter int unsigned       DATA_W      = 198,
  parameter int unsigned       SKID        = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  if (SKID != 0) begin : g_skid
    state_t            state;
    logic              inReadyQ;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic [DATA_W-1:0] mainData, skidData;
    logic              inFire, outFire;

    assign inFire  = in_valid & inReadyQ;
    assign outFire = (state != EMPTY) & out_ready;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        state    <= EMPTY;
        inReadyQ <= 1'b0;
        mainCtrl <= BUBBLE_CTRL;
        mainData <= '0;
        skidCtrl <= '0;
        skidData <= '0;
      end else if (flush) begin
        state    <= EMPTY;
        inReadyQ <= 1'b1;
        mainCtrl <= BUBBLE_CTRL;
      end else begin
        case (state)
          EMPTY: begin
            inReadyQ <= 1'b1;
            if (inFire) begin
              state    <= ONE;
              mainCtrl <= in_ctrl;
              mainData <= in_data;
            end
          end
          ONE: begin
            inReadyQ <= 1'b1;
            if (inFire && outFire) begin
              mainCtrl <= in_ctrl;
              mainData <= in_data;
            end else if (inFire) begin
              state    <= TWO;
              inReadyQ <= 1'b0;
              skidCtrl <= in_ctrl;
              skidData <= in_data;
            end else if (outFire) begin
              state    <= EMPTY;
              mainCtrl <= BUBBLE_CTRL;
            end
          end
          TWO: begin
            // in_ready is low here, so only the drain of the head can happen.
            if (outFire) begin
              state    <= ONE;
              inReadyQ <= 1'b1;
              mainCtrl <= skidCtrl;
              mainData <= skidData;
            end
          end
          default: begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
            mainCtrl <= BUBBLE_CTRL;
          end
        endcase
      end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = mainCtrl;
    assign out_data  = mainData;
    assign occupancy = state;
  end else begin : g_single
    logic              started;
    logic              validQ;
    logic [CTRL_W-1:0] ctrlQ;
    logic [DATA_W-1:0] dataQ;
    logic              inFire, outFire;

    // started keeps in_ready low while in reset and until the first edge after release.
    assign in_ready = started & (~validQ | out_ready);
    assign inFire   = in_valid & in_ready;
    assign outFire  = validQ & out_ready;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        started <= 1'b0;
        validQ  <= 1'b0;
        ctrlQ   <= BUBBLE_CTRL;
        dataQ   <= '0;
      end else begin
        started <= 1'b1;
        if (flush) begin
          validQ <= 1'b0;
          ctrlQ  <= BUBBLE_CTRL;
        end else if (inFire) begin
          validQ <= 1'b1;
          ctrlQ  <= in_ctrl;
          dataQ  <= in_data;
        end else if (outFire) begin
          validQ <= 1'b0;
          ctrlQ  <= BUBBLE_CTRL;
        end
      end
    end

    assign out_valid = validQ;
    assign out_ctrl  = ctrlQ;
    assign out_data  = dataQ;
    assign occupancy = {1'b0, validQ};
  end

endmodule
